// File: rtl/tone_sequencer.sv
// tone_sequencer: queues note requests (step divider + duration) in a
// 4-entry FIFO and plays them one after another by pacing a sine LUT
// generator through step_en / sine_rst / mute.
// Optional build macro TONE_SEQ_GAP_EN inserts a GAP_UNITS-long silence
// after every note; without it notes run back-to-back with one LOAD cycle.
module tone_sequencer #(
  parameter int DIV_W     = 16,
  parameter int DUR_W     = 16,
  parameter int UNIT_CYC  = 1000,
  parameter int GAP_UNITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [DIV_W-1:0] req_div,
  input  logic [DUR_W-1:0] req_dur,
  output logic             step_en,
  output logic             sine_rst,
  output logic             mute,
  output logic             note_done,
  output logic             busy,
  output logic [2:0]       fifo_level
);

  localparam int UNIT_W = $clog2(UNIT_CYC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
`ifdef TONE_SEQ_GAP_EN
  localparam logic [1:0] S_GAP  = 2'd3;
  localparam int GAP_CYC = GAP_UNITS * UNIT_CYC;
  localparam int GAP_W   = $clog2(GAP_CYC);
`endif

  // Elaboration-time guard on the minimum legal parameter values.
  if (UNIT_CYC < 2 || GAP_UNITS < 1) begin : g_param_check
    $error("tone_sequencer: UNIT_CYC must be >= 2 and GAP_UNITS >= 1");
  end

  // ---------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] fifo_div [4];
  logic [DUR_W-1:0] fifo_dur [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic             push;
  logic             pop;

  logic [1:0]       state;
  logic [1:0]       state_d;

  assign req_ready  = (count != 3'd4);
  assign fifo_level = count;
  assign push       = req_valid && req_ready;
  assign pop        = (state == S_LOAD) && (count != 3'd0);

  // FIFO storage, pointers and occupancy; requests in reset cycles are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_div[i] <= '0;
        fifo_dur[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_div[wr_ptr] <= req_div;
        fifo_dur[wr_ptr] <= req_dur;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Note playback datapath
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DUR_W-1:0]  rem_q;
  logic [UNIT_W-1:0] unit_cnt;
  logic              unit_wrap;
  logic              div_hit;
  logic              last_play;
`ifdef TONE_SEQ_GAP_EN
  logic [GAP_W-1:0]  gap_cnt;
  logic              gap_done;
  assign gap_done = (gap_cnt == GAP_W'(GAP_CYC - 1));
`endif

  assign unit_wrap = (unit_cnt == UNIT_W'(UNIT_CYC - 1));
  // div_q - 1 is only meaningful when div_q != 0, which the AND guards.
  assign div_hit   = (div_q != '0) && (div_cnt == (div_q - DIV_W'(1)));
  // rem_q never drops below 1 in PLAY; <= keeps the exit safe regardless.
  assign last_play = (state == S_PLAY) && unit_wrap && (rem_q <= DUR_W'(1));

  // Next-state selection for the IDLE/LOAD/PLAY(/GAP) sequencer.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE: begin
        if (count != 3'd0 || push) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = S_PLAY;
      end
      S_PLAY: begin
        if (last_play) begin
`ifdef TONE_SEQ_GAP_EN
          state_d = S_GAP;
`else
          state_d = (count != 3'd0) ? S_LOAD : S_IDLE;
`endif
        end
      end
`ifdef TONE_SEQ_GAP_EN
      S_GAP: begin
        if (gap_done) begin
          state_d = (count != 3'd0) ? S_LOAD : S_IDLE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register plus latched note parameters and the divider/unit counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      div_q    <= '0;
      rem_q    <= '0;
      div_cnt  <= '0;
      unit_cnt <= '0;
    end else begin
      state <= state_d;
      case (state)
        S_LOAD: begin
          div_q    <= fifo_div[rd_ptr];
          rem_q    <= (fifo_dur[rd_ptr] == '0) ? DUR_W'(1) : fifo_dur[rd_ptr];
          div_cnt  <= '0;
          unit_cnt <= '0;
        end
        S_PLAY: begin
          if (div_hit) begin
            div_cnt <= '0;
          end else if (div_q != '0) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
          if (unit_wrap) begin
            unit_cnt <= '0;
            if (rem_q != '0) begin
              rem_q <= rem_q - DUR_W'(1);
            end
          end else begin
            unit_cnt <= unit_cnt + UNIT_W'(1);
          end
        end
        default: begin
          div_cnt  <= div_cnt;
          unit_cnt <= unit_cnt;
        end
      endcase
    end
  end

`ifdef TONE_SEQ_GAP_EN
  // Silence timer: restarts on the last PLAY cycle, runs through GAP.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (last_play) begin
      gap_cnt <= '0;
    end else if (state == S_GAP) begin
      gap_cnt <= gap_cnt + GAP_W'(1);
    end
  end
`endif

  // Output decode; a rest note (div 0) keeps the generator muted and held.
  always_comb begin
    mute      = 1'b1;
    sine_rst  = 1'b1;
    step_en   = 1'b0;
    note_done = 1'b0;
    if (state == S_PLAY) begin
      mute      = (div_q == '0);
      sine_rst  = (div_q == '0);
      step_en   = div_hit;
      note_done = last_play;
    end
  end

  assign busy = (state != S_IDLE) || (count != 3'd0);

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed self-checking bench for tone_sequencer (UNIT_CYC=4, GAP_UNITS=2).
// Expectations follow TONE_SEQ_GAP_EN when it is defined for the build.
module tb_tone_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_div;
  logic [15:0] req_dur;
  logic        step_en;
  logic        sine_rst;
  logic        mute;
  logic        note_done;
  logic        busy;
  logic [2:0]  fifo_level;

  int tests;
  int fails;
  int steps_acc;
  int done_q[$];

`ifdef TONE_SEQ_GAP_EN
  localparam int BP_WAIT = 17;
`else
  localparam int BP_WAIT = 9;
`endif

  tone_sequencer #(
    .DIV_W    (16),
    .DUR_W    (16),
    .UNIT_CYC (4),
    .GAP_UNITS(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_div   (req_div),
    .req_dur   (req_dur),
    .step_en   (step_en),
    .sine_rst  (sine_rst),
    .mute      (mute),
    .note_done (note_done),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-note signature: number of step_en pulses up to and including note_done.
  always @(negedge clk) begin
    if (reset) begin
      steps_acc = 0;
    end else begin
      if (step_en) steps_acc++;
      if (note_done) begin
        done_q.push_back(steps_acc);
        steps_acc = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input logic [15:0] d, input logic [15:0] u);
    req_valid = 1'b1;
    req_div   = d;
    req_dur   = u;
    tick();
  endtask

  initial begin
    int base;
    int waited;
    tests     = 0;
    fails     = 0;
    steps_acc = 0;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_div   = 16'd5;
    req_dur   = 16'd1;

    // Reset, with a request offered during reset cycles.
    tick();
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    chk("rst_step_en",   {31'd0, step_en},   0);
    chk("rst_note_done", {31'd0, note_done}, 0);
    chk("rst_sine_rst",  {31'd0, sine_rst},  1);
    chk("rst_mute",      {31'd0, mute},      1);
    chk("rst_busy",      {31'd0, busy},      0);
    chk("rst_level",     {29'd0, fifo_level}, 0);
    chk("rst_ready",     {31'd0, req_ready}, 1);
    tick();
    chk("rst_req_ignored", {29'd0, fifo_level}, 0);
    chk("rst_idle_busy",   {31'd0, busy},       0);

    // Single note div=3 dur=2: 8 PLAY cycles, steps at 2 and 5, done at 7.
    base = done_q.size();
    push(16'd3, 16'd2);
    req_valid = 1'b0;
    chk("one_load_mute",  {31'd0, mute},     1);
    chk("one_load_srst",  {31'd0, sine_rst}, 1);
    chk("one_load_level", {29'd0, fifo_level}, 1);
    chk("one_load_busy",  {31'd0, busy},     1);
    tick();
    chk("one_play_level", {29'd0, fifo_level}, 0);
    for (int p = 0; p < 8; p++) begin
      chk("one_step", {31'd0, step_en},   (p == 2 || p == 5) ? 1 : 0);
      chk("one_done", {31'd0, note_done}, (p == 7) ? 1 : 0);
      chk("one_mute", {31'd0, mute},      0);
      chk("one_srst", {31'd0, sine_rst},  0);
      tick();
    end
    chk("one_after_mute", {31'd0, mute},      1);
    chk("one_after_done", {31'd0, note_done}, 0);
`ifdef TONE_SEQ_GAP_EN
    chk("one_after_busy", {31'd0, busy}, 1);
`else
    chk("one_after_busy", {31'd0, busy}, 0);
`endif
    wait_idle(50);
    chk("one_done_count", done_q.size() - base, 1);

    // Rest note div=0 dur=1.
    base = done_q.size();
    push(16'd0, 16'd1);
    req_valid = 1'b0;
    tick();
    for (int p = 0; p < 4; p++) begin
      chk("rest_mute", {31'd0, mute},      1);
      chk("rest_step", {31'd0, step_en},   0);
      chk("rest_done", {31'd0, note_done}, (p == 3) ? 1 : 0);
      tick();
    end
    wait_idle(50);
    chk("rest_done_count", done_q.size() - base, 1);

    // Edge: div=1 dur=0 -> step every PLAY cycle for one unit.
    push(16'd1, 16'd0);
    req_valid = 1'b0;
    tick();
    for (int p = 0; p < 4; p++) begin
      chk("edge_step", {31'd0, step_en},   1);
      chk("edge_done", {31'd0, note_done}, (p == 3) ? 1 : 0);
      tick();
    end
    chk("edge_after_step", {31'd0, step_en}, 0);
    wait_idle(50);

    // Two queued notes: gap (or single LOAD) between them; push+pop in LOAD.
    push(16'd2, 16'd1);
    chk("gap_load_level", {29'd0, fifo_level}, 1);
    push(16'd2, 16'd1);
    req_valid = 1'b0;
    chk("gap_pushpop_level", {29'd0, fifo_level}, 1);
    for (int p = 0; p < 4; p++) begin
      chk("gapA_step", {31'd0, step_en},   (p == 1 || p == 3) ? 1 : 0);
      chk("gapA_done", {31'd0, note_done}, (p == 3) ? 1 : 0);
      chk("gapA_mute", {31'd0, mute},      0);
      tick();
    end
`ifdef TONE_SEQ_GAP_EN
    for (int g = 0; g < 8; g++) begin
      chk("gap_mute",  {31'd0, mute},     1);
      chk("gap_srst",  {31'd0, sine_rst}, 1);
      chk("gap_step",  {31'd0, step_en},  0);
      chk("gap_level", {29'd0, fifo_level}, 1);
      tick();
    end
`endif
    chk("gap_load_mute",  {31'd0, mute},     1);
    chk("gap_load_srst",  {31'd0, sine_rst}, 1);
    chk("gap_load_lvl",   {29'd0, fifo_level}, 1);
    tick();
    chk("gapB_mute",  {31'd0, mute},      0);
    chk("gapB_level", {29'd0, fifo_level}, 0);
    wait_idle(50);

    // Backpressure: 5 requests while a note plays; order checked by signatures.
    base = done_q.size();
    push(16'd2, 16'd3);
    req_valid = 1'b0;
    tick();
    push(16'd1, 16'd1);
    push(16'd1, 16'd2);
    push(16'd2, 16'd1);
    push(16'd1, 16'd3);
    chk("bp_ready_full", {31'd0, req_ready}, 0);
    chk("bp_level_full", {29'd0, fifo_level}, 4);
    req_valid = 1'b1;
    req_div   = 16'd0;
    req_dur   = 16'd2;
    waited    = 0;
    while (!req_ready && waited < 100) begin
      waited++;
      tick();
      chk("bp_held_level", {29'd0, fifo_level} == 0 ? 0 : 1, 1);
    end
    chk("bp_wait", waited, BP_WAIT);
    tick();
    req_valid = 1'b0;
    chk("bp_level_after", {29'd0, fifo_level}, 4);
    wait_idle(300);
    chk("bp_note_count", done_q.size() - base, 6);
    if (done_q.size() - base == 6) begin
      chk("bp_sig0", done_q[base + 0], 6);
      chk("bp_sig1", done_q[base + 1], 4);
      chk("bp_sig2", done_q[base + 2], 8);
      chk("bp_sig3", done_q[base + 3], 2);
      chk("bp_sig4", done_q[base + 4], 12);
      chk("bp_sig5", done_q[base + 5], 0);
    end

    // Reset in the 3rd PLAY cycle of a dur=5 note with two more queued.
    base = done_q.size();
    push(16'd2, 16'd5);
    push(16'd3, 16'd1);
    push(16'd4, 16'd1);
    req_valid = 1'b0;
    chk("mid_level", {29'd0, fifo_level}, 2);
    chk("mid_mute",  {31'd0, mute},       0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_level", {29'd0, fifo_level}, 0);
    chk("mid_rst_busy",  {31'd0, busy},       0);
    chk("mid_rst_srst",  {31'd0, sine_rst},   1);
    chk("mid_rst_mute",  {31'd0, mute},       1);
    chk("mid_rst_done",  {31'd0, note_done},  0);
    chk("mid_rst_ready", {31'd0, req_ready},  1);
    for (int i = 0; i < 20; i++) tick();
    chk("mid_no_done", done_q.size() - base, 0);
    chk("mid_still_idle", {31'd0, busy}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the per-note step divider.
REQ-002 SHALL have parameter DUR_W, default 16, width of the per-note duration.
REQ-003 SHALL have parameter UNIT_CYC, default 1000, clk cycles per duration unit, minimum 2.
REQ-004 SHALL have parameter GAP_UNITS, default 2, number of silence units between notes, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: a note request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: a request can be accepted.
REQ-009 SHALL have port req_div, input, DIV_W bits: clk cycles per sine step; 0 means rest.
REQ-010 SHALL have port req_dur, input, DUR_W bits: note length in units; 0 is treated as 1.
REQ-011 SHALL have port step_en, output, 1 bit: single-cycle pulse that advances the sine generator one LUT step.
REQ-012 SHALL have port sine_rst, output, 1 bit: drives the sine generator reset.
REQ-013 SHALL have port mute, output, 1 bit: high when no tone is playing.
REQ-014 SHALL have port note_done, output, 1 bit: single-cycle pulse at the end of each note.
REQ-015 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE or the FIFO is not empty.
REQ-016 SHALL have port fifo_level, output, 3 bits: number of queued requests, 0 to 4.

Function
REQ-017 SHALL queue requests in a 4-entry FIFO; req_ready = (fifo_level != 4); a push occurs when req_valid and req_ready are both high.
REQ-018 SHALL allow a push and a pop in the same cycle, leaving fifo_level unchanged.
REQ-019 SHALL hold the FIFO contents and drop nothing while req_valid is high and the FIFO is full.
REQ-020 SHALL implement the states IDLE, LOAD, PLAY, GAP.
REQ-021 IDLE behaviour: mute=1 and sine_rst=1; go to LOAD in the cycle after fifo_level becomes nonzero.
REQ-022 LOAD behaviour, one cycle: pop the FIFO head, latch div and dur (dur 0 becomes 1), clear both counters, sine_rst=1; next state PLAY.
REQ-023 PLAY divider: counts 0 to div-1 and wraps; step_en=1 in the cycles where the count equals div-1 and div != 0.
REQ-024 PLAY timing: the first step_en occurs div-1 cycles after PLAY entry; div=1 gives step_en in every PLAY cycle.
REQ-025 PLAY with div=0 (rest): step_en=0 and mute=1 throughout; otherwise mute=0 and sine_rst=0 in PLAY.
REQ-026 PLAY unit counter: counts 0 to UNIT_CYC-1; at each wrap it decrements the remaining duration.
REQ-027 PLAY exit: the wrap at which remaining equals 1 is the last PLAY cycle; note_done=1 in that cycle.
REQ-028 Next state after PLAY: GAP if the gap feature is compiled in; else LOAD if the FIFO is non-empty; else IDLE.
REQ-029 GAP behaviour: mute=1, sine_rst=1, step_en=0 for GAP_UNITS*UNIT_CYC cycles; then LOAD if the FIFO is non-empty, else IDLE.
REQ-030 SHALL treat all counters as unsigned and use no arithmetic that can overflow: the duration is decremented only while it is at least 1.
REQ-031 SHALL keep accepting requests in every state, including the cycle in which LOAD pops the FIFO.
REQ-032 Latency: a request pushed at cycle N into an empty FIFO while IDLE gives LOAD at N+1 and PLAY entry at N+2.

Reset
REQ-033 SHALL, while reset=1 on a clk edge, enter IDLE, empty the FIFO and clear all counters and latched values.
REQ-034 Output reset values: step_en=0, note_done=0, sine_rst=1, mute=1, busy=0, fifo_level=0, req_ready=1.
REQ-035 SHALL abort any note in progress when reset is asserted mid-note, with no note_done pulse.
REQ-036 SHALL ignore a request presented in a reset cycle.

Configuration
REQ-037 SHALL compile in the GAP state when the macro TONE_SEQ_GAP_EN is defined.
REQ-038 Without TONE_SEQ_GAP_EN, the GAP state and its counter SHALL be absent and PLAY SHALL exit directly as in REQ-028, giving back-to-back notes with one LOAD cycle between them, in which sine_rst=1.

Verification
REQ-039 Bench parameters for all scenarios: UNIT_CYC=4, GAP_UNITS=2.
REQ-040 Single note: push div=3, dur=2 while IDLE -> PLAY lasts 8 cycles; step_en at PLAY cycles 2 and 5; note_done in PLAY cycle 7; then IDLE with mute=1.
REQ-041 Rest note: push div=0, dur=1 -> 4 PLAY cycles with mute=1 and step_en=0; one note_done pulse.
REQ-042 Backpressure: push 5 requests back-to-back while a note plays -> req_ready=0 after the 4th push with fifo_level=4; the 5th request is held and accepted after the next LOAD; all 5 notes play in order.
REQ-043 Gap: with TONE_SEQ_GAP_EN, two queued notes -> 8 GAP cycles with mute=1 between them; without the macro -> exactly 1 LOAD cycle between them.
REQ-044 Reset mid-note: assert reset in the 3rd PLAY cycle of a dur=5 note with 2 more queued -> next cycle IDLE, fifo_level=0, no note_done, sine_rst=1.
REQ-045 Edge values: div=1, dur=0 -> step_en in all 4 PLAY cycles, then note_done.
